// File: rtl/pulse_toggle_tx_if.sv
// Event-strobe side of the pulse-to-toggle transmitter: strobes in, toggle level and status out.
// Latency: none, this is only a signal bundle.
// Backpressure: none here; the transmitter holds events in its pending counter while enable_i is low.
interface pulse_toggle_tx_if #(
    parameter int CNT_W = 4
);
    logic             pulse_i;
    logic             enable_i;
    logic             flush_i;
    logic             toggle_o;
    logic             sent_o;
    logic             busy_o;
    logic [CNT_W-1:0] pend_cnt_o;
    logic             ovf_o;

    // Event source side: drives strobes and controls, observes status.
    modport master (
        output pulse_i,
        output enable_i,
        output flush_i,
        input  toggle_o,
        input  sent_o,
        input  busy_o,
        input  pend_cnt_o,
        input  ovf_o
    );

    // Transmitter side.
    modport slave (
        input  pulse_i,
        input  enable_i,
        input  flush_i,
        output toggle_o,
        output sent_o,
        output busy_o,
        output pend_cnt_o,
        output ovf_o
    );
endinterface

// File: rtl/pulse_toggle_tx.sv
// Counts event strobes and forwards each as one toggle_o edge, at least GAP cycles apart.
// Latency: pulse to toggle edge 2 cycles; enable rise with backlog to toggle edge 1 cycle.
// Backpressure: enable_i low or an active gap holds events in a saturating counter; overflow is sticky.
module pulse_toggle_tx #(
    parameter int GAP   = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk_high_i,
    input  logic              rst_i,
    pulse_toggle_tx_if.slave  bus
);
    localparam int               GAP_W      = $clog2(GAP);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic [CNT_W-1:0] pend_cnt_q;
    logic [CNT_W-1:0] pend_cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             toggle_q;
    logic             toggle_d;
    logic             sent_q;
    logic             send;
    logic             can_send;
    logic             cnt_full;

    // A send needs a backlog, permission, and no flush in the same cycle.
    assign can_send = bus.enable_i && !bus.flush_i && (pend_cnt_q != '0);
    assign cnt_full = (pend_cnt_q == CNT_MAX);

    // Sequencer: decide sends and keep the inter-edge spacing; the gap runs regardless of enable/flush.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        send      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_send) begin
                    send      = 1'b1;
                    gap_cnt_d = GAP_RELOAD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    // Back-to-back sends with a backlog land exactly GAP cycles apart.
                    if (can_send) begin
                        send      = 1'b1;
                        gap_cnt_d = GAP_RELOAD;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // Pending counter and overflow flag: flush wins, a simultaneous pulse and send cancel out.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        ovf_d      = ovf_q;
        toggle_d   = toggle_q ^ send;
        if (bus.flush_i) begin
            pend_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (bus.pulse_i && !send) begin
            if (cnt_full) begin
                ovf_d      = 1'b1;
            end else begin
                pend_cnt_d = pend_cnt_q + 1'b1;
            end
        end else if (!bus.pulse_i && send) begin
            pend_cnt_d = pend_cnt_q - 1'b1;
        end
    end

    // State and output registers; reset drops any backlog and an in-flight gap.
    always_ff @(posedge clk_high_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            pend_cnt_q <= '0;
            ovf_q      <= 1'b0;
            toggle_q   <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            pend_cnt_q <= pend_cnt_d;
            ovf_q      <= ovf_d;
            toggle_q   <= toggle_d;
            sent_q     <= send;
        end
    end

    assign bus.toggle_o   = toggle_q;
    assign bus.sent_o     = sent_q;
    assign bus.pend_cnt_o = pend_cnt_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.busy_o     = (pend_cnt_q != '0) || (state_q == ST_GAP);
endmodule
